// File: rtl/im_loader.sv
// ---------------------------------------------------------------------------
// im_loader
//   Receives a program image byte-by-byte from a UART receiver and writes it
//   into instruction memory one 32-bit word at a time.
//
//   Stream: N (16-bit LE), N words (4 bytes each, LE), 1 checksum byte that
//   equals the XOR of every preceding byte of the stream.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   start     one-cycle load request (honoured only when not busy)
//   rx_data   received byte, qualified by rx_valid
//   rx_valid  one-cycle strobe per received byte
//   we        one-cycle instruction-memory write enable
//   waddr     byte address of the word being written (multiple of 4)
//   wdata     assembled 32-bit word
//   busy      high while a load is in progress
//   done      level, high after a successful load
//   err       level, high after a failed load
//   err_code  01 bad length, 10 checksum mismatch, 11 timeout, 00 otherwise
// ---------------------------------------------------------------------------
module im_loader #(
  parameter int ADDR_W         = 16,
  parameter int MAX_WORDS      = 64,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  // Gap value at which the next idle cycle makes the count hit the limit.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]      MAX_N    = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERR
  } state_t;

  state_t            state, state_n;
  logic [15:0]       len, len_n;
  logic [15:0]       word_idx, word_idx_n;
  logic [1:0]        byte_idx, byte_idx_n;
  logic [23:0]       part, part_n;
  logic [7:0]        csum, csum_n;
  logic [GAP_W-1:0]  gap, gap_n;
  logic              we_n;
  logic [ADDR_W-1:0] waddr_n;
  logic [31:0]       wdata_n;
  logic [1:0]        code_n;
  logic [15:0]       n_rx;

  // Full length as it will be once the high byte in rx_data is taken.
  assign n_rx = {rx_data, len[7:0]};

  assign busy = (state == LEN_LO) || (state == LEN_HI) ||
                (state == DATA)   || (state == CHECK);
  assign done = (state == DONE);
  assign err  = (state == ERR);

  always_comb begin
    state_n    = state;
    len_n      = len;
    word_idx_n = word_idx;
    byte_idx_n = byte_idx;
    part_n     = part;
    csum_n     = csum;
    gap_n      = gap;
    we_n       = 1'b0;
    waddr_n    = waddr;
    wdata_n    = wdata;
    code_n     = err_code;

    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_n    = LEN_LO;
          len_n      = '0;
          word_idx_n = '0;
          byte_idx_n = '0;
          csum_n     = '0;
          gap_n      = '0;
          code_n     = 2'b00;
        end
      end
      default: begin
        // rx_valid wins over an expiring gap counter in the same cycle.
        if (rx_valid) begin
          gap_n = '0;
          case (state)
            LEN_LO: begin
              len_n   = {8'h00, rx_data};
              csum_n  = csum ^ rx_data;
              state_n = LEN_HI;
            end
            LEN_HI: begin
              len_n  = n_rx;
              csum_n = csum ^ rx_data;
              if (n_rx == 16'd0 || n_rx > MAX_N) begin
                state_n = ERR;
                code_n  = 2'b01;
              end else begin
                state_n = DATA;
              end
            end
            DATA: begin
              csum_n     = csum ^ rx_data;
              byte_idx_n = byte_idx + 2'd1;
              case (byte_idx)
                2'd0: part_n[7:0]   = rx_data;
                2'd1: part_n[15:8]  = rx_data;
                2'd2: part_n[23:16] = rx_data;
                default: begin
                  we_n       = 1'b1;
                  wdata_n    = {rx_data, part};
                  waddr_n    = ADDR_W'({word_idx, 2'b00});
                  word_idx_n = word_idx + 16'd1;
                  if (word_idx == len - 16'd1) state_n = CHECK;
                end
              endcase
            end
            default: begin
              if (rx_data == csum) begin
                state_n = DONE;
              end else begin
                state_n = ERR;
                code_n  = 2'b10;
              end
            end
          endcase
        end else if (gap == GAP_LAST) begin
          state_n = ERR;
          code_n  = 2'b11;
        end else begin
          gap_n = gap + 1'b1;
        end
      end
    endcase
  end

  // Register stage: all state, counters and write-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      len      <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      part     <= '0;
      csum     <= '0;
      gap      <= '0;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      err_code <= 2'b00;
    end else begin
      state    <= state_n;
      len      <= len_n;
      word_idx <= word_idx_n;
      byte_idx <= byte_idx_n;
      part     <= part_n;
      csum     <= csum_n;
      gap      <= gap_n;
      we       <= we_n;
      waddr    <= waddr_n;
      wdata    <= wdata_n;
      err_code <= code_n;
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// ---------------------------------------------------------------------------
// tb_im_loader
//   Self-checking bench for im_loader. Images are built from random data,
//   driven with random inter-byte gaps, and the captured writes and final
//   status are compared with a stream-level reference model.
// ---------------------------------------------------------------------------
module tb_im_loader;

  localparam int ADDR_W  = 16;
  localparam int MAXW    = 64;
  localparam int TMO     = 40;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        err_code;

  im_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAXW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .we(we), .waddr(waddr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  stim[$];
  logic [47:0] cap[$];
  logic [47:0] exp_w[$];
  logic        exp_done, exp_err;
  logic [1:0]  exp_code;

  // Write monitor: one entry per cycle with we high.
  always @(negedge clk) if (we) cap.push_back({waddr, wdata});

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: interpret the byte stream directly from the format rules.
  task automatic model();
    int n;
    logic [7:0] x;
    exp_w.delete();
    exp_done = 1'b0; exp_err = 1'b0; exp_code = 2'b00;
    n = int'({stim[1], stim[0]});
    if (n == 0 || n > MAXW) begin
      exp_err = 1'b1; exp_code = 2'b01;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < 2 + 4 * n; i++) x ^= stim[i];
    for (int k = 0; k < n; k++)
      exp_w.push_back({16'(4 * k), stim[2+4*k+3], stim[2+4*k+2],
                       stim[2+4*k+1], stim[2+4*k]});
    if (stim[2+4*n] == x) exp_done = 1'b1;
    else begin exp_err = 1'b1; exp_code = 2'b10; end
  endtask

  task automatic make_img(input int n, input bit good);
    logic [7:0] x;
    logic [15:0] nn;
    nn = 16'(n);
    stim.delete();
    stim.push_back(nn[7:0]);
    stim.push_back(nn[15:8]);
    if (n == 0 || n > MAXW) return;
    for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom_range(0, 255)));
    x = 8'h00;
    foreach (stim[i]) x ^= stim[i];
    if (!good) x ^= 8'($urandom_range(1, 255));
    stim.push_back(x);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
  endtask

  task automatic run_load(input bit poke_start);
    int t;
    cap.delete();
    model();
    pulse_start();
    check("busy_after_start", busy, 1);
    check("status_cleared", {done, err, err_code}, 0);
    foreach (stim[i]) begin
      send_byte(stim[i]);
      if (poke_start && i == 0) begin
        start = 1'b1; @(negedge clk); start = 1'b0;
      end
    end
    t = 0;
    while (!(done || err) && t < 50) begin @(negedge clk); t++; end
    check("finished", done | err, 1);
    check("n_writes", cap.size(), exp_w.size());
    for (int i = 0; i < exp_w.size(); i++)
      if (i < cap.size()) check("write", cap[i], exp_w[i]);
    check("done", done, exp_done);
    check("err", err, exp_err);
    check("err_code", err_code, exp_code);
    check("busy_end", busy, 0);
  endtask

  initial begin
    logic [87:0] v;
    int n, t;
    rst = 1'b1; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {we, waddr, wdata, busy, done, err, err_code}, 0);
    rst = 1'b0;
    // Bytes without start must not leave IDLE.
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h55);
    repeat (2) @(negedge clk);
    check("idle_no_start", {busy, done, err, we}, 0);

    // Known two-word image.
    v = 88'h0200B705F80303A84501A4;
    stim.delete();
    for (int i = 0; i < 11; i++) stim.push_back(v[87-8*i -: 8]);
    run_load(0);
    if (cap.size() >= 2) begin
      check("w0_const", cap[0], {16'h0000, 32'h03F805B7});
      check("w1_const", cap[1], {16'h0004, 32'h0145A803});
    end
    check("done_const", {done, err}, 2'b10);

    // Same image with a bad checksum.
    stim[10] = 8'hA5;
    run_load(0);
    check("bad_csum_const", {done, err, err_code}, 4'b0110);

    // Bad lengths.
    make_img(0, 1);  run_load(0);
    make_img(65, 1); run_load(0);
    check("len65_code", err_code, 2'b01);

    // Boundary: maximum word count.
    make_img(MAXW, 1); run_load(0);

    // Timeout after 3 bytes of a one-word image.
    cap.delete();
    pulse_start();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h12);
    repeat (TMO - 3) @(negedge clk);
    check("tmo_not_early", err, 0);
    t = 0;
    while (!err && t < 10) begin @(negedge clk); t++; end
    check("tmo_err", {err, err_code}, 3'b111);
    check("tmo_no_we", cap.size(), 0);
    check("tmo_busy", busy, 0);

    // Reset mid-word on a 64-word load.
    make_img(MAXW, 1);
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(stim[i]);
    #2 rst = 1'b1;
    @(negedge clk);
    check("midrst_outputs", {we, waddr, wdata, busy, done, err, err_code}, 0);
    rst = 1'b0;
    @(negedge clk);
    make_img(1, 1);
    run_load(0);

    // Stray bytes in DONE/ERR plus a start while busy.
    send_byte(8'hAA); send_byte(8'h03);
    check("stray_ignored", busy, 0);
    make_img(3, 1);
    run_load(1);

    // Randomised images.
    for (int it = 0; it < 14; it++) begin
      case ($urandom_range(0, 9))
        0: n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(65, 300));
        1: n = MAXW;
        default: n = int'($urandom_range(1, 8));
      endcase
      make_img(n, $urandom_range(0, 3) != 0);
      run_load($urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, which is the width of the write address (it matches the instruction-memory pc width).
REQ-002 SHALL have parameter MAX_WORDS, default 64, which is the largest word count accepted per image.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 100000, which is the allowed idle gap in clk cycles between received bytes while loading.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 start  input  1  one-cycle request to begin a load; sampled only in IDLE, DONE or ERR.
REQ-008 rx_data  input  8  byte from the UART receiver, valid only when rx_valid=1.
REQ-009 rx_valid  input  1  one-cycle strobe marking one received byte.
REQ-010 we  output  1  one-cycle instruction-memory write enable.
REQ-011 waddr  output  ADDR_W  byte address of the word being written; always a multiple of 4.
REQ-012 wdata  output  32  assembled instruction word.
REQ-013 busy  output  1  high while a load is in progress.
REQ-014 done  output  1  level output; high after a successful load.
REQ-015 err  output  1  level output; high after a failed load.
REQ-016 err_code  output  2  failure cause: 01 bad length, 10 checksum mismatch, 11 timeout; 00 when err=0.

Function
REQ-017 SHALL implement the states IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE and ERR.
REQ-018 SHALL move from IDLE, DONE or ERR to LEN_LO on start=1, clearing done, err, err_code, the checksum accumulator, the word index and the byte index in the same edge.
REQ-019 SHALL ignore start while busy=1, and SHALL ignore rx_valid in IDLE, DONE and ERR.
REQ-020 SHALL define the stream format as: length N as a 16-bit little-endian value, then N words of 4 bytes each, each word little-endian, then 1 checksum byte.
REQ-021 SHALL go from LEN_LO to LEN_HI on a byte, and from LEN_HI to DATA on a byte when 1 <= N <= MAX_WORDS.
REQ-022 SHALL go from LEN_HI to ERR with err_code=01 when N=0 or N>MAX_WORDS.
REQ-023 SHALL place data byte j (0..3) of a word into wdata bits [8j+7:8j].
REQ-024 SHALL register we=1 for exactly one cycle, starting on the edge that samples the 4th byte of a word, with waddr=4*k for word k (0-based) and wdata equal to the full word.
REQ-025 SHALL hold wdata and waddr stable while we=1; their values when we=0 are don't-care.
REQ-026 SHALL go to CHECK after the write of word N-1.
REQ-027 SHALL compute the checksum as the 8-bit XOR of every byte from the first length byte through the last data byte.
REQ-028 SHALL, in CHECK, go to DONE (done=1) on a received byte equal to the checksum, and otherwise go to ERR with err_code=10.
REQ-029 SHALL NOT roll back words already written when a load fails; err only flags the image as invalid.
REQ-030 SHALL, in LEN_LO, LEN_HI, DATA and CHECK, run a gap counter that resets on every rx_valid and on entry from start.
REQ-031 SHALL go to ERR with err_code=11 on the edge where the gap counter reaches TIMEOUT_CYCLES.
REQ-032 SHALL give rx_valid priority over timeout when both occur in the same cycle.
REQ-033 SHALL drive busy=1 exactly in LEN_LO, LEN_HI, DATA and CHECK.
REQ-034 SHALL hold done and err until the next accepted start or rst; done and err are never both 1.
REQ-035 SHALL accept a start issued in the same cycle that done or err is set only from the following cycle onward.

Reset
REQ-036 SHALL, on rst=1 and at any time including mid-load, force state IDLE, we=0, waddr=0, wdata=0, busy=0, done=0, err=0, err_code=00, clear all counters and the checksum accumulator, and discard any partial word.
REQ-037 SHALL leave IDLE after reset only on a start.

Verification
REQ-038 Start, then bytes 02 00 B7 05 F8 03 03 A8 45 01 A4 -> we pulses with (addr 0, 03F805B7) and (addr 4, 0145A803), then done=1, busy=0.
REQ-039 Same stream with a final byte of A5 -> both writes occur, then err=1, err_code=10, done=0.
REQ-040 Start, then bytes 00 00 -> err=1, err_code=01, no we; repeat with 41 00 (N=65) -> same result.
REQ-041 Start, then 3 bytes of a 1-word image, then TIMEOUT_CYCLES idle cycles -> err=1, err_code=11, no we.
REQ-042 rst asserted mid-word on a 64-word load, then a new start and a valid 1-word image -> only the single write at addr 0 with the correct data, then done=1.
REQ-043 rx_valid bytes before start and a start issued while busy -> both ignored; the load result is unchanged.
